// File: rtl/adder_pipelined.sv
// adder_pipelined
//   WIDTH-bit adder split into STAGES equal chunks, one chunk resolved per
//   pipeline stage with the carry rippling stage to stage. Full-throughput
//   valid/ready handshakes. The whole pipeline freezes while the output
//   is held by the consumer.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a, b, carry_in are valid
//   in_ready   block can accept operands (= !stall, combinational)
//   a, b       operands, WIDTH bits (unsigned or two's complement)
//   carry_in   carry into bit 0
//   out_valid  sum/carry_out/overflow are valid
//   out_ready  consumer accepts the result
//   sum        a + b + carry_in modulo 2^WIDTH
//   carry_out  carry out of bit WIDTH-1
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
module adder_pipelined #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("adder_pipelined: WIDTH must be >= 2 and divisible by STAGES");
  end

  // Stage registers: index k holds the result of computing chunk k.
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0]            c_q, v_q;
  logic                         ovf_q;

  // Inputs feeding each stage (stage 0 from the ports, others from k-1).
  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src, s_nx;
  logic [STAGES-1:0]            c_src, v_src, c_nx;
  logic                         ovf_nx;
  logic [CHUNK:0]               part;
  logic                         stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign a_src[0] = a;
      assign b_src[0] = b;
      assign s_src[0] = '0;
      assign c_src[0] = carry_in;
      assign v_src[0] = in_valid;
    end else begin : g_next
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign v_src[k] = v_q[k-1];
    end
  end

  always_comb begin
    part   = '0;
    s_nx   = s_src;
    c_nx   = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
           + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, c_src[k]};
      s_nx[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_nx[k] = part[CHUNK];
    end
    // part now holds the top chunk. Carry into the MSB is recovered from
    // the MSB sum bit: s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
    ovf_nx = a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1]
           ^ part[CHUNK-1] ^ part[CHUNK];
  end

  assign stall    = v_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      // Bubbles shift along too; their data is don't-care.
      v_q   <= v_src;
      a_q   <= a_src;
      b_q   <= b_src;
      s_q   <= s_nx;
      c_q   <= c_nx;
      ovf_q <= ovf_nx;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ovf_q;

  // Last-stage operand copies have no consumer; synthesis trims them.
  logic unused_ok;
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule
